// File: rtl/serial_tx_framer.sv
// serial_tx_framer
// Sends one asynchronous serial frame (start bit, DATA_W data bits LSB-first,
// optional even parity, one stop bit) on each rising edge of trans_enable
// seen while idle.
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   trans_enable         frame request level; a rising edge starts a frame
//   tx_data [DATA_W]     frame payload, sampled only in the start cycle
//   tx                   serial line, idle high (registered)
//   busy                 high while a frame is on the line (registered)
//   done                 one-cycle pulse after the stop bit (registered)
//   frame_count [16]     completed frames, wraps at 2^16
module serial_tx_framer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trans_enable,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_count
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  logic              en_d;
  logic [DATA_W-1:0] shift;
  logic              parity;
  logic [CNT_W-1:0]  baud_cnt;
  logic [IDX_W-1:0]  bit_idx;

  logic start_c;
  logic bit_end_c;

  // Edge detect against the previous-cycle level; only honoured in IDLE.
  assign start_c   = trans_enable & ~en_d & (state == S_IDLE);
  assign bit_end_c = (baud_cnt == CNT_LAST);

  // Frame sequencer; tx/busy/done are driven with the value for the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      en_d        <= 1'b0;
      shift       <= '0;
      parity      <= 1'b0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      en_d <= trans_enable;
      done <= 1'b0;

      if (state != S_IDLE) begin
        baud_cnt <= bit_end_c ? '0 : baud_cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start_c) begin
            shift    <= tx_data;
            parity   <= ^tx_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end_c) begin
            state <= S_DATA;
            tx    <= shift[0];
          end
        end

        S_DATA: begin
          if (bit_end_c) begin
            if (bit_idx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                tx    <= parity;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              // shift[1] becomes shift[0] after this edge, so present it now.
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (bit_end_c) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end_c) begin
            state       <= S_IDLE;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: two instances (without and with parity) share
// clock, reset and request inputs. A frame-schedule model predicts every
// output cycle by cycle; directed sections pin the model with literal values.
module tb_serial_tx_framer;

  localparam int unsigned CPB = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             te;
  logic [7:0]       td;
  logic [1:0]       tx_o, busy_o, done_o;
  logic [1:0][15:0] fc_o;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model state, one slot per instance (index = PARITY_EN).
  logic       act [2];
  int         e_cyc [2];
  logic [7:0] md [2];
  logic [15:0] mcnt [2];
  logic       prev_en;
  int         preload_seq  = 0;
  int         preload_seen = 0;

  always #5 clk = ~clk;

  serial_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) u0 (
    .clk(clk), .reset_n(reset_n), .trans_enable(te), .tx_data(td),
    .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]), .frame_count(fc_o[0])
  );

  serial_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) u1 (
    .clk(clk), .reset_n(reset_n), .trans_enable(te), .tx_data(td),
    .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]), .frame_count(fc_o[1])
  );

  task automatic check(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, i, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the frame schedule; runs on the falling edge.
  always @(negedge clk) begin
    int n, off, b;
    logic etx, eb, ed;
    cyc++;
    if (preload_seq != preload_seen) begin
      mcnt[0] = 16'hFFFF;
      mcnt[1] = 16'hFFFF;
      preload_seen = preload_seq;
    end
    for (int i = 0; i < 2; i++) begin
      n = (10 + i) * CPB;
      if (!reset_n) begin
        act[i]  = 1'b0;
        mcnt[i] = 16'd0;
      end
      off = cyc - e_cyc[i];
      etx = 1'b1;
      eb  = 1'b0;
      ed  = 1'b0;
      if (act[i] && off >= 1 && off <= n) begin
        eb = 1'b1;
        b  = (off - 1) / CPB;
        if (b == 0)                 etx = 1'b0;
        else if (b <= 8)            etx = md[i][b-1];
        else if (i == 1 && b == 9)  etx = ^md[i];
      end
      if (act[i] && off == n + 1) begin
        ed = 1'b1;
        mcnt[i] = mcnt[i] + 16'd1;
      end
      check("tx", i, 16'(tx_o[i]), 16'(etx));
      check("busy", i, 16'(busy_o[i]), 16'(eb));
      check("done", i, 16'(done_o[i]), 16'(ed));
      check("frame_count", i, fc_o[i], mcnt[i]);
    end
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        n = (10 + i) * CPB;
        if (te && !prev_en && (!act[i] || (cyc - e_cyc[i]) > n)) begin
          act[i]   = 1'b1;
          e_cyc[i] = cyc;
          md[i]    = td;
        end
      end
      prev_en = te;
    end else begin
      prev_en = 1'b0;
    end
  end

  // Raise a request and watch ~60 cycles: busy lengths, done count, parity bit.
  task automatic run_frame(input logic [7:0] data, output int bl0, output int bl1,
                           output logic pbit, output int dn0);
    te = 1'b0;
    tick();
    td = data;
    te = 1'b1;
    bl0 = 0; bl1 = 0; dn0 = 0; pbit = 1'bx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy_o[0]) bl0++;
      if (busy_o[1]) begin
        bl1++;
        if (bl1 == 37) pbit = tx_o[1];
      end
      if (done_o[0]) dn0++;
    end
  endtask

  initial begin
    logic [9:0]  pat;
    logic [7:0]  rx;
    logic [15:0] fc_before [2];
    int bl0, bl1, dn0, bl;
    logic pbit;

    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; e_cyc[i] = 0; md[i] = '0; mcnt[i] = '0;
    end
    prev_en = 1'b0;
    reset_n = 1'b0;
    te      = 1'b0;
    td      = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check("reset_tx", 0, 16'(tx_o[0]), 16'd1);
    check("reset_busy", 0, 16'(busy_o[0]), 16'd0);
    check("reset_count", 0, fc_o[0], 16'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single 0xA5 frame: line pattern 0,1,0,1,0,0,1,0,1,1 (4 cycles each).
    pat = 10'b1101001010;
    td  = 8'hA5;
    te  = 1'b1;
    bl  = 0;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("a5_line", 0, 16'(tx_o[0]), 16'(pat[k/4]));
      if (busy_o[0]) bl++;
    end
    @(negedge clk);
    check("a5_done", 0, 16'(done_o[0]), 16'd1);
    check("a5_busy_end", 0, 16'(busy_o[0]), 16'd0);
    check("a5_count", 0, fc_o[0], 16'd1);
    check("a5_busy_len", 0, 16'(bl), 16'd40);

    // trans_enable still high: no further frame.
    bl = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_o[0]) bl++;
    end
    check("held_high_no_frame", 0, 16'(bl), 16'd0);

    // Parity frames.
    run_frame(8'h07, bl0, bl1, pbit, dn0);
    check("p07_len0", 0, 16'(bl0), 16'd40);
    check("p07_len1", 1, 16'(bl1), 16'd44);
    check("p07_parity", 1, 16'(pbit), 16'd1);
    check("p07_done", 0, 16'(dn0), 16'd1);
    run_frame(8'h03, bl0, bl1, pbit, dn0);
    check("p03_parity", 1, 16'(pbit), 16'd0);
    check("p03_len1", 1, 16'(bl1), 16'd44);

    // Re-toggle during a frame is ignored.
    te = 1'b0;
    tick();
    fc_before[0] = fc_o[0];
    fc_before[1] = fc_o[1];
    td = 8'($urandom);
    te = 1'b1;
    repeat (10) tick();
    te = 1'b0;
    tick();
    te = 1'b1;
    repeat (55) tick();
    check("toggle_once0", 0, fc_o[0] - fc_before[0], 16'd1);
    check("toggle_once1", 1, fc_o[1] - fc_before[1], 16'd1);

    // tx_data change after start has no effect.
    te = 1'b0;
    tick();
    td = 8'h5A;
    te = 1'b1;
    tick();
    tick();
    td = 8'hFF;
    rx = '0;
    for (int o = 2; o <= 40; o++) begin
      @(negedge clk);
      if (o >= 5 && ((o - 5) % 4) == 0 && ((o - 5) / 4) < 8) rx[(o-5)/4] = tx_o[0];
    end
    check("stable_data", 0, 16'(rx), 16'h005A);
    repeat (10) tick();

    // Reset during a data bit, request held high through release.
    te = 1'b0;
    tick();
    td = 8'($urandom);
    te = 1'b1;
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_tx", i, 16'(tx_o[i]), 16'd1);
      check("rst_busy", i, 16'(busy_o[i]), 16'd0);
      check("rst_done", i, 16'(done_o[i]), 16'd0);
      check("rst_count", i, fc_o[i], 16'd0);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", 0, 16'(busy_o[0]), 16'd1);
    check("post_rst_tx", 0, 16'(tx_o[0]), 16'd0);

    // Random requests; the per-cycle model carries the checking.
    repeat (60) begin
      td = 8'($urandom);
      te = 1'($urandom);
      repeat ($urandom_range(1, 30)) tick();
    end

    // Counter wrap from a preloaded 0xFFFF.
    te = 1'b0;
    repeat (60) tick();
    force u0.frame_count = 16'hFFFF;
    force u1.frame_count = 16'hFFFF;
    preload_seq++;
    #1;
    release u0.frame_count;
    release u1.frame_count;
    tick();
    td = 8'($urandom);
    te = 1'b1;
    repeat (55) tick();
    check("wrap0", 0, fc_o[0], 16'h0000);
    check("wrap1", 1, fc_o[1], 16'h0000);
    te = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
